// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared constants, register-select type and byte-lane helper for
//            the memory-mapped interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Register offsets from BASE (low five address bits of the window)
  localparam logic [4:0] IRQ_PEND   = 5'h00;
  localparam logic [4:0] IRQ_MASK   = 5'h04;
  localparam logic [4:0] IRQ_MODE   = 5'h08;
  localparam logic [4:0] IRQ_ID     = 5'h0C;
  localparam logic [4:0] IRQ_ROUTE0 = 5'h10;
  localparam logic [4:0] IRQ_ROUTE1 = 5'h14;

  // ID value returned when nothing is both pending and enabled
  localparam logic [31:0] IRQ_NONE = 32'h20;

  // Route nibble software writes to disconnect a source (any of 6..15 works)
  localparam logic [3:0] IRQ_UNROUTED = 4'd15;

  // Number of HWInt lines into CP0
  localparam int IRQ_NLINES = 6;

  // Decoded register select
  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_PEND   = 3'd1,
    SEL_MASK   = 3'd2,
    SEL_MODE   = 3'd3,
    SEL_ID     = 3'd4,
    SEL_ROUTE0 = 3'd5,
    SEL_ROUTE1 = 3'd6
  } irq_sel_e;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] irq_lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Combinational lowest-index-first priority encoder; returns the
//            index of the lowest set request bit, or the IRQ_NONE code.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 16
) (
  input  logic [NSRC-1:0] req,
  output logic [5:0]      id
);

  // Scan from the top so the lowest set index is the last one assigned
  always_comb begin
    id = IRQ_NONE[5:0];
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) id = 6'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Memory-mapped interrupt controller. Latches up to NSRC sources
//            as pending, masks and routes them onto six registered HWInt
//            lines, and exposes PEND/MASK/MODE/ID/ROUTE0/ROUTE1 registers.
// Options  : IRQ_CTRL_EDGE_EN - adds the MODE register, the src_q history and
//            per-source edge detection with write-1-to-clear on PEND.
//            Without it every source is level-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F20,
  parameter int          NSRC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     addr,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic [5:0]      HWInt
);

  logic [NSRC-1:0]   pend;
  logic [NSRC-1:0]   mask;
  logic [4*NSRC-1:0] route_q;
  logic [5:0]        hwint_q;

  logic [31:0]       w_off;
  irq_sel_e          w_sel;
  logic              w_wr;
  logic [31:0]       w_lane;
  logic [NSRC-1:0]   w_active;
  logic [NSRC-1:0]   w_pend_nxt;
  logic [5:0]        w_id;
  logic [63:0]       w_route64;
  logic [63:0]       w_route_nxt;
  logic [5:0]        w_hw_nxt;

  // Offset wraps to a huge value below BASE, so one compare bounds both ends
  assign w_off  = addr - BASE;
  assign hit    = (addr[1:0] == 2'b00) && (w_off <= 32'h14);
  assign w_wr   = hit && (byteen != 4'b0000);
  assign w_lane = irq_lane_mask(byteen);

  assign w_active  = pend & mask;
  assign w_route64 = 64'(route_q);

  // Decode the register addressed by this bus cycle
  always_comb begin
    w_sel = SEL_NONE;
    if (hit) begin
      case (w_off[4:0])
        IRQ_PEND:   w_sel = SEL_PEND;
        IRQ_MASK:   w_sel = SEL_MASK;
        IRQ_MODE:   w_sel = SEL_MODE;
        IRQ_ID:     w_sel = SEL_ID;
        IRQ_ROUTE0: w_sel = SEL_ROUTE0;
        IRQ_ROUTE1: w_sel = SEL_ROUTE1;
        default:    w_sel = SEL_NONE;
      endcase
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] w_clr;

  // W1C only touches enabled byte lanes; set beats clear on edge sources
  assign w_clr      = (w_wr && (w_sel == SEL_PEND)) ?
                      (wdata[NSRC-1:0] & w_lane[NSRC-1:0]) : '0;
  assign w_pend_nxt = (mode & ((src & ~src_q) | (pend & ~w_clr))) |
                      (~mode & src);

  // MODE register and one-cycle source history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      mode  <= '0;
      src_q <= '0;
    end else begin
      src_q <= src;
      if (w_wr && (w_sel == SEL_MODE))
        mode <= (mode & ~w_lane[NSRC-1:0]) | (wdata[NSRC-1:0] & w_lane[NSRC-1:0]);
    end
  end
`else
  // Every source is level-sensitive: pending simply tracks the request line
  assign w_pend_nxt = src;
`endif

  // ROUTE0/ROUTE1 byte-lane merge into the packed nibble store
  always_comb begin
    w_route_nxt = w_route64;
    if (w_wr && (w_sel == SEL_ROUTE0))
      w_route_nxt[31:0] = (w_route64[31:0] & ~w_lane) | (wdata & w_lane);
    if (w_wr && (w_sel == SEL_ROUTE1))
      w_route_nxt[63:32] = (w_route64[63:32] & ~w_lane) | (wdata & w_lane);
  end

  // OR-tree: each line collects every active source whose nibble names it
  always_comb begin
    w_hw_nxt = '0;
    for (int k = 0; k < IRQ_NLINES; k++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_active[i] && (route_q[4*i +: 4] == 4'(k))) w_hw_nxt[k] = 1'b1;
      end
    end
  end

  // Pending, mask, route and HWInt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend    <= '0;
      mask    <= '0;
      route_q <= '0;
      hwint_q <= '0;
    end else begin
      pend    <= w_pend_nxt;
      route_q <= w_route_nxt[4*NSRC-1:0];
      hwint_q <= w_hw_nxt;
      if (w_wr && (w_sel == SEL_MASK))
        mask <= (mask & ~w_lane[NSRC-1:0]) | (wdata[NSRC-1:0] & w_lane[NSRC-1:0]);
    end
  end

  assign HWInt = hwint_q;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req (w_active),
    .id  (w_id)
  );

  // Read mux returns pre-edge register contents; unselected reads give 0
  always_comb begin
    rdata = 32'h0;
    case (w_sel)
      SEL_PEND:   rdata = 32'(pend);
`ifdef IRQ_CTRL_EDGE_EN
      SEL_MODE:   rdata = 32'(mode);
`else
      SEL_MODE:   rdata = 32'h0;
`endif
      SEL_MASK:   rdata = 32'(mask);
      SEL_ID:     rdata = 32'(w_id);
      SEL_ROUTE0: rdata = w_route64[31:0];
      SEL_ROUTE1: rdata = w_route64[63:32];
      default:    rdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Self-checking bench for irq_ctrl: directed scenarios followed by
//            random bus/source traffic, all compared against a behavioural
//            model of the register map and pending/route rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F20;
  localparam int          NSRC = 16;
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic [5:0]  HWInt;

  int checks = 0;
  int errors = 0;

  // Model state: one entry per source / per line
  bit m_pend [16];
  bit m_mask [16];
  bit m_mode [16];
  bit m_srcq [16];
  int m_route[16];
  bit m_hw   [6];

  always #5 clk = ~clk;

  irq_ctrl #(
    .BASE (BASE),
    .NSRC (NSRC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .HWInt  (HWInt)
  );

  function automatic bit m_hit(logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd20) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] v = 32'h0;
    int off;
    if (!m_hit(a)) return 32'h0;
    off = int'(a - BASE);
    case (off)
      0:  for (int i = 0; i < 16; i++) v[i] = m_pend[i];
      4:  for (int i = 0; i < 16; i++) v[i] = m_mask[i];
      8:  for (int i = 0; i < 16; i++) v[i] = EDGE_EN && m_mode[i];
      12: begin
        v = 32'd32;
        for (int i = 15; i >= 0; i--) if (m_pend[i] && m_mask[i]) v = 32'(i);
      end
      16, 20: for (int j = 0; j < 8; j++) v[4*j +: 4] = 4'(m_route[(off == 20 ? 8 : 0) + j]);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [5:0] m_hw_vec();
    logic [5:0] v;
    for (int k = 0; k < 6; k++) v[k] = m_hw[k];
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic auto_check();
    check("hit", 32'(hit), 32'(m_hit(addr)));
    check("rdata", rdata, m_read(addr));
    check("hwint", 32'(HWInt), 32'(m_hw_vec()));
  endtask

  // Drive bus inputs just after the falling edge and compare with the model
  task automatic drive(logic [31:0] a, logic [3:0] be, logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    #1;
    auto_check();
  endtask

  // Compute the model's next state from the current inputs, then clock
  task automatic tick();
    bit n_pend[16], n_mask[16], n_mode[16], n_srcq[16];
    int n_route[16];
    bit n_hw[6];
    bit wr, lane, clr;
    int off;
    bit rst_now = reset;
    wr  = m_hit(addr) && (byteen != 4'b0);
    off = int'(addr - BASE);
    for (int k = 0; k < 6; k++) begin
      n_hw[k] = 1'b0;
      for (int i = 0; i < 16; i++)
        if (m_pend[i] && m_mask[i] && m_route[i] == k) n_hw[k] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      lane = byteen[i / 8];
      clr  = wr && off == 0 && lane && wdata[i] && EDGE_EN;
      if (EDGE_EN && m_mode[i]) n_pend[i] = (src[i] && !m_srcq[i]) || (m_pend[i] && !clr);
      else                      n_pend[i] = src[i];
      n_mask[i]  = (wr && off == 4 && lane) ? wdata[i] : m_mask[i];
      n_mode[i]  = (wr && off == 8 && lane && EDGE_EN) ? wdata[i] : m_mode[i];
      n_srcq[i]  = src[i];
      n_route[i] = m_route[i];
      if (wr && off == ((i >= 8) ? 20 : 16) && byteen[(i % 8) / 2])
        n_route[i] = int'(wdata[4*(i % 8) +: 4]);
    end
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      m_pend[i]  = rst_now ? 1'b0 : n_pend[i];
      m_mask[i]  = rst_now ? 1'b0 : n_mask[i];
      m_mode[i]  = rst_now ? 1'b0 : n_mode[i];
      m_srcq[i]  = rst_now ? 1'b0 : n_srcq[i];
      m_route[i] = rst_now ? 0 : n_route[i];
    end
    for (int k = 0; k < 6; k++) m_hw[k] = rst_now ? 1'b0 : n_hw[k];
    @(negedge clk);
  endtask

  task automatic op(logic [31:0] a, logic [3:0] be, logic [31:0] d);
    drive(a, be, d);
    tick();
  endtask

  logic [31:0] r0, r1, ra;

  initial begin
    reset = 1'b1; src = '0; addr = '0; byteen = '0; wdata = '0;
    @(negedge clk);
    op(32'h0, 4'h0, 32'h0);
    op(32'h0, 4'h0, 32'h0);
    reset = 1'b0;

    // Reset state
    drive(BASE + 32'h0C, 4'h0, 32'h0);
    check("reset_id", rdata, 32'h20);
    check("reset_hwint", 32'(HWInt), 32'h0);
    tick();

    // Masked level source 3
    src = 16'h0008;
    op(BASE, 4'h0, 32'h0);
    drive(BASE, 4'h0, 32'h0);
    check("masked_pend", rdata, 32'h8);
    check("masked_hwint", 32'(HWInt), 32'h0);
    tick();
    drive(BASE + 32'h0C, 4'h0, 32'h0);
    check("masked_id", rdata, 32'h20);
    tick();
    src = '0;
    op(BASE, 4'h0, 32'h0);

    // Source 0 routed to line 2, one-cycle pulse
    op(BASE + 32'h08, 4'hF, 32'h1);
    op(BASE + 32'h04, 4'hF, 32'h1);
    op(BASE + 32'h10, 4'hF, 32'hFFFF_FFF2);
    src = 16'h0001;
    op(BASE, 4'h0, 32'h0);
    src = '0;
    op(BASE, 4'h0, 32'h0);
    drive(BASE, 4'h0, 32'h0);
    check("edge_hwint", 32'(HWInt), 32'h4);
    tick();
`ifdef IRQ_CTRL_EDGE_EN
    drive(BASE, 4'h0, 32'h0);
    check("edge_hold", 32'(HWInt), 32'h4);
    tick();
`endif
    op(BASE, 4'hF, 32'h1);
    op(BASE, 4'h0, 32'h0);
    drive(BASE, 4'h0, 32'h0);
    check("w1c_hwint", 32'(HWInt), 32'h0);
    tick();

    // Set and clear in the same cycle
    src = 16'h0001;
    op(BASE, 4'hF, 32'h1);
    drive(BASE, 4'h0, 32'h0);
    check("collide_pend0", 32'(rdata[0]), 32'h1);
    tick();
    src = '0;
    op(BASE, 4'hF, 32'h1);
    op(BASE, 4'h0, 32'h0);

    // Priority with two level sources sharing line 0
    r0 = {8{IRQ_UNROUTED}}; r0[23:20] = 4'd0;
    r1 = {8{IRQ_UNROUTED}}; r1[7:4]   = 4'd0;
    op(BASE + 32'h08, 4'hF, 32'h0);
    op(BASE + 32'h04, 4'hF, 32'h220);
    op(BASE + 32'h10, 4'hF, r0);
    op(BASE + 32'h14, 4'hF, r1);
    src = 16'h0220;
    op(BASE, 4'h0, 32'h0);
    op(BASE, 4'h0, 32'h0);
    drive(BASE + 32'h0C, 4'h0, 32'h0);
    check("prio_id5", rdata, 32'd5);
    check("prio_hw5", 32'(HWInt), 32'h1);
    tick();
    src = 16'h0200;
    op(BASE, 4'h0, 32'h0);
    drive(BASE + 32'h0C, 4'h0, 32'h0);
    check("prio_id9", rdata, 32'd9);
    check("prio_hw9", 32'(HWInt), 32'h1);
    tick();

    // Bus corner cases
    op(BASE + 32'h04, 4'b0001, 32'hFFFF_FFFF);
    drive(BASE + 32'h04, 4'h0, 32'h0);
    check("lane_mask", rdata, 32'h2FF);
    tick();
    drive(BASE + 32'h02, 4'hF, 32'hFFFF_FFFF);
    check("misalign_hit", 32'(hit), 32'h0);
    check("misalign_rdata", rdata, 32'h0);
    tick();
    drive(BASE + 32'h04, 4'h0, 32'h0);
    check("misalign_nowrite", rdata, 32'h2FF);
    tick();
    op(BASE + 32'h0C, 4'hF, 32'h0);
    drive(BASE + 32'h0C, 4'h0, 32'h0);
    check("id_readonly", rdata, 32'd9);
    tick();
    drive(BASE + 32'h18, 4'hF, 32'hFFFF_FFFF);
    check("gap_hit", 32'(hit), 32'h0);
    tick();

    // Reset while line 0 is active, with a bus write in the same cycle
    drive(BASE + 32'h04, 4'hF, 32'hFFFF);
    check("pre_reset_hw", 32'(HWInt), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(BASE + 32'h04, 4'h0, 32'h0);
    check("post_reset_mask", rdata, 32'h0);
    check("post_reset_hw", 32'(HWInt), 32'h0);
    tick();
    src = '0;
    op(BASE, 4'h0, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      src   = 16'($urandom) & 16'($urandom);
      ra    = BASE - 32'd4 + 32'd4 * $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) ra = ra + $urandom_range(1, 3);
      drive(ra, 4'($urandom), $urandom);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
